// File: rtl/wave_ram_arbiter_pkg.sv
// Shared geometry defaults and helpers for the wave RAM read arbiter.
// Bank-select width derivation and packed-bus slice offsets live here so every block agrees.
package wave_ram_arbiter_pkg;
    localparam int DEF_NUM_CH    = 3;
    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_DATAWIDTH = 16;
    localparam int DEF_ADDRWIDTH = 8;

    // A single bank or channel still needs a one-bit select field.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant over NUM_CH requesters, search starting after the last winner.
// Latency: grant is combinational from req_i and the priority pointer.
// Backpressure: none; the pointer moves only when a grant is issued.
module rr_arbiter
    import wave_ram_arbiter_pkg::*;
#(
    parameter int  NUM_CH = DEF_NUM_CH,
    localparam int CHW    = clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req_i,
    output logic [NUM_CH-1:0] gnt_o
);
    logic [CHW-1:0] ptr_q, ptr_d;

    always_comb begin
        int off;
        int best_off;
        int best;
        gnt_o    = '0;
        ptr_d    = ptr_q;
        off      = 0;
        best_off = NUM_CH;
        best     = 0;
        // Distance from the pointer decides priority; nearest requester wins.
        for (int i = 0; i < NUM_CH; i++) begin
            off = i - int'(ptr_q);
            if (off < 0) begin
                off = off + NUM_CH;
            end
            if (req_i[i] && (off < best_off)) begin
                best_off = off;
                best     = i;
            end
        end
        if (best_off < NUM_CH) begin
            for (int i = 0; i < NUM_CH; i++) begin
                gnt_o[i] = (i == best);
            end
            ptr_d = (best == NUM_CH - 1) ? '0 : CHW'(best + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/wave_ram_arbiter.sv
// Multi-bank wavetable RAM with one broadcast write port and one round-robin shared read path.
// Latency: grant in cycle N -> RAM read at edge N+1 -> RDATA/RD_VALID in cycle N+2.
// Backpressure: requesters hold RD_REQ until granted; writes never stall reads.
module wave_ram_arbiter
    import wave_ram_arbiter_pkg::*;
#(
    parameter int  NUM_CH    = DEF_NUM_CH,
    parameter int  NUM_BANKS = DEF_NUM_BANKS,
    parameter int  DATAWIDTH = DEF_DATAWIDTH,
    parameter int  ADDRWIDTH = DEF_ADDRWIDTH,
    localparam int BANKW     = clog2_min1(NUM_BANKS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        WE,
    input  logic [NUM_BANKS-1:0]        WBANK,
    input  logic [ADDRWIDTH-1:0]        WADDR,
    input  logic [DATAWIDTH-1:0]        WDATA,
    input  logic [NUM_CH-1:0]           RD_REQ,
    input  logic [NUM_CH*BANKW-1:0]     RBANK,
    input  logic [NUM_CH*ADDRWIDTH-1:0] RADDR,
    output logic [NUM_CH-1:0]           RD_GNT,
    output logic [NUM_CH-1:0]           RD_VALID,
    output logic [NUM_CH*DATAWIDTH-1:0] RDATA
);
    logic [NUM_CH-1:0]              req;
    logic [NUM_CH-1:0]              gnt;
    logic                           wr_en;
    logic [BANKW-1:0]               sel_bank;
    logic [ADDRWIDTH-1:0]           sel_addr;
    logic [NUM_BANKS*DATAWIDTH-1:0] bank_rd;
    logic [DATAWIDTH-1:0]           s1_dat;

    logic [NUM_CH-1:0]           s1_gnt_q, s1_gnt_d;
    logic [BANKW-1:0]            s1_bank_q, s1_bank_d;
    logic [NUM_CH-1:0]           rd_valid_q, rd_valid_d;
    logic [NUM_CH*DATAWIDTH-1:0] rdata_q, rdata_d;

    // Held reset blocks both grants and writes, not only the flops.
    assign req   = RD_REQ & {NUM_CH{rst_n}};
    assign wr_en = WE & rst_n;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign RD_GNT = gnt;

    always_comb begin
        sel_bank = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_bank = RBANK[slice_lo(i, BANKW) +: BANKW];
                sel_addr = RADDR[slice_lo(i, ADDRWIDTH) +: ADDRWIDTH];
            end
        end
    end

    // One simple dual-port array per bank; read-before-write gives old data on collision.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATAWIDTH-1:0] mem [2**ADDRWIDTH];
        logic [DATAWIDTH-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (wr_en && WBANK[b]) begin
                mem[WADDR] <= WDATA;
            end
            rd_q <= mem[sel_addr];
        end

        assign bank_rd[b*DATAWIDTH +: DATAWIDTH] = rd_q;
    end

    always_comb begin
        s1_gnt_d  = gnt;
        s1_bank_d = sel_bank;
        s1_dat    = '0;
        // Bank selects with no matching bank fall through as zero data.
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (int'(s1_bank_q) == b) begin
                s1_dat = bank_rd[slice_lo(b, DATAWIDTH) +: DATAWIDTH];
            end
        end
        rd_valid_d = s1_gnt_q;
        rdata_d    = rdata_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (s1_gnt_q[i]) begin
                rdata_d[slice_lo(i, DATAWIDTH) +: DATAWIDTH] = s1_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_gnt_q   <= '0;
            s1_bank_q  <= '0;
            rd_valid_q <= '0;
            rdata_q    <= '0;
        end else begin
            s1_gnt_q   <= s1_gnt_d;
            s1_bank_q  <= s1_bank_d;
            rd_valid_q <= rd_valid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign RD_VALID = rd_valid_q;
    assign RDATA    = rdata_q;
endmodule

// File: tb/tb_wave_ram_arbiter.sv
// Self-checking bench for wave_ram_arbiter: directed vector table, corner sequences,
// and constrained-random traffic scored against a transaction-level model.
module tb_wave_ram_arbiter;
    localparam int NCH = 3;
    localparam int NB  = 4;

    logic        clk;
    logic        rst_n;
    logic        WE;
    logic [3:0]  WBANK;
    logic [7:0]  WADDR;
    logic [15:0] WDATA;
    logic [2:0]  RD_REQ;
    logic [5:0]  RBANK;
    logic [23:0] RADDR;
    logic [2:0]  RD_GNT, RD_VALID, gnt3, vld3;
    logic [47:0] RDATA, rdata3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wave_ram_arbiter dut (
        .clk(clk), .rst_n(rst_n), .WE(WE), .WBANK(WBANK), .WADDR(WADDR), .WDATA(WDATA),
        .RD_REQ(RD_REQ), .RBANK(RBANK), .RADDR(RADDR),
        .RD_GNT(RD_GNT), .RD_VALID(RD_VALID), .RDATA(RDATA)
    );

    // Three-bank copy sharing all inputs: bank select 3 is out of range there.
    wave_ram_arbiter #(.NUM_BANKS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .WE(WE), .WBANK(WBANK[2:0]), .WADDR(WADDR), .WDATA(WDATA),
        .RD_REQ(RD_REQ), .RBANK(RBANK), .RADDR(RADDR),
        .RD_GNT(gnt3), .RD_VALID(vld3), .RDATA(rdata3)
    );

    typedef struct packed {
        logic        rst;
        logic        we;
        logic [3:0]  wbank;
        logic [7:0]  waddr;
        logic [15:0] wdata;
        logic [2:0]  req;
        logic [5:0]  rb;
        logic [23:0] ra;
    } in_t;

    typedef struct {
        in_t         in;
        logic [2:0]  exp_gnt;
        logic [2:0]  exp_vld;
        logic        chk_d0;
        logic [15:0] exp_d0;
    } vec_t;

    typedef struct {
        int          t;
        int          ch;
        logic [15:0] d4;
        logic [15:0] d3;
    } ev_t;

    // Transaction-level model state
    logic [15:0] mem_m [NB][256];
    ev_t         evq[$];
    int          last_m;
    logic [15:0] rdata_m  [NCH];
    logic [15:0] rdata3_m [NCH];
    int          now;

    logic [2:0]  m_gnt, obs_gnt, obs_vld, obs_vld3;
    logic [47:0] obs_rdata, obs_rdata3;
    int          n_chk, n_fail;

    vec_t tbl [21];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, now);
        end
    endtask

    function automatic in_t mk(input logic rst, input logic we, input logic [3:0] wb,
                               input logic [7:0] wa, input logic [15:0] wd,
                               input logic [2:0] rq, input logic [5:0] rb, input logic [23:0] ra);
        in_t v;
        v.rst = rst; v.we = we; v.wbank = wb; v.waddr = wa; v.wdata = wd;
        v.req = rq; v.rb = rb; v.ra = ra;
        return v;
    endfunction

    function automatic in_t rd(input logic [2:0] rq, input logic [5:0] rb, input logic [23:0] ra);
        return mk(1'b1, 1'b0, 4'h0, 8'h0, 16'h0, rq, rb, ra);
    endfunction

    // Round-robin rule: first requester after the last one served.
    function automatic int pick(input logic [2:0] r);
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (last_m + k) % NCH;
            if (((r >> c) & 3'b001) != 3'b000) return c;
        end
        return -1;
    endfunction

    task automatic cyc(input in_t v);
        int g;
        int b;
        int a;
        logic [2:0] eg;
        logic [2:0] ev;
        rst_n  = v.rst;
        WE     = v.we;
        WBANK  = v.wbank;
        WADDR  = v.waddr;
        WDATA  = v.wdata;
        RD_REQ = v.req;
        RBANK  = v.rb;
        RADDR  = v.ra;
        @(negedge clk);
        eg = 3'b000;
        ev = 3'b000;
        if (!v.rst) begin
            evq.delete();
            last_m = NCH - 1;
            for (int c = 0; c < NCH; c++) begin
                rdata_m[c]  = 16'h0;
                rdata3_m[c] = 16'h0;
            end
        end else begin
            while (evq.size() > 0 && evq[0].t == now) begin
                ev = ev | 3'(1 << evq[0].ch);
                rdata_m[evq[0].ch]  = evq[0].d4;
                rdata3_m[evq[0].ch] = evq[0].d3;
                void'(evq.pop_front());
            end
            g = pick(v.req);
            if (g >= 0) begin
                eg = 3'(1 << g);
                b  = int'((v.rb >> (2 * g)) & 6'h03);
                a  = int'((v.ra >> (8 * g)) & 24'h0000FF);
                evq.push_back('{now + 2, g, mem_m[b][a], (b < 3) ? mem_m[b][a] : 16'h0});
                last_m = g;
            end
        end
        chk("rd_gnt", 64'(RD_GNT), 64'(eg));
        chk("rd_valid", 64'(RD_VALID), 64'(ev));
        chk("rdata", 64'(RDATA), 64'({rdata_m[2], rdata_m[1], rdata_m[0]}));
        chk("rd_gnt_nb3", 64'(gnt3), 64'(eg));
        chk("rd_valid_nb3", 64'(vld3), 64'(ev));
        chk("rdata_nb3", 64'(rdata3), 64'({rdata3_m[2], rdata3_m[1], rdata3_m[0]}));
        m_gnt      = eg;
        obs_gnt    = RD_GNT;
        obs_vld    = RD_VALID;
        obs_vld3   = vld3;
        obs_rdata  = RDATA;
        obs_rdata3 = rdata3;
        if (v.rst && v.we) begin
            for (int k = 0; k < NB; k++) begin
                if (((v.wbank >> k) & 4'h1) != 4'h0) mem_m[k][v.waddr] = v.wdata;
            end
        end
        now++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_t         idle;
        logic        pend [NCH];
        logic [1:0]  pb   [NCH];
        logic [7:0]  pa   [NCH];
        int          wt   [NCH];
        logic [5:0]  cr;
        logic [23:0] ca;

        n_chk  = 0;
        n_fail = 0;
        now    = 0;
        last_m = NCH - 1;
        rst_n  = 1'b0;
        WE     = 1'b0;
        WBANK  = 4'h0;
        WADDR  = 8'h0;
        WDATA  = 16'h0;
        RD_REQ = 3'b000;
        RBANK  = 6'h0;
        RADDR  = 24'h0;
        idle   = rd(3'b000, 6'h0, 24'h0);
        cr     = {2'd2, 2'd1, 2'd0};
        ca     = 24'h030201;
        @(posedge clk);
        #1;

        // Reset state, then fill every bank/address with {bank, addr}
        cyc(mk(1'b0, 1'b0, 4'h0, 8'h0, 16'h0, 3'b000, 6'h0, 24'h0));
        chk("reset_rdata", 64'(obs_rdata), 64'h0);
        for (int b = 0; b < NB; b++) begin
            for (int a = 0; a < 256; a++) begin
                cyc(mk(1'b1, 1'b1, 4'(1 << b), 8'(a), 16'((b << 8) | a), 3'b000, 6'h0, 24'h0));
            end
        end
        for (int b = 0; b < NB; b++) begin
            for (int a = 0; a < 256; a++) begin
                cyc(rd(3'b001, 6'(b), 24'(a)));
            end
        end
        cyc(idle);
        cyc(idle);
        chk("fill_last_word", 64'(obs_rdata[15:0]), 64'h03FF);

        // Directed table: contention, broadcast write with same-cycle read
        tbl[0]  = '{mk(1'b0, 1'b0, 4'h0, 8'h0, 16'h0, 3'b000, 6'h0, 24'h0), 3'b000, 3'b000, 1'b1, 16'h0000};
        tbl[1]  = '{rd(3'b111, cr, ca), 3'b001, 3'b000, 1'b0, 16'h0};
        tbl[2]  = '{rd(3'b111, cr, ca), 3'b010, 3'b000, 1'b0, 16'h0};
        tbl[3]  = '{rd(3'b111, cr, ca), 3'b100, 3'b001, 1'b1, 16'h0001};
        tbl[4]  = '{rd(3'b111, cr, ca), 3'b001, 3'b010, 1'b0, 16'h0};
        tbl[5]  = '{rd(3'b111, cr, ca), 3'b010, 3'b100, 1'b0, 16'h0};
        tbl[6]  = '{rd(3'b111, cr, ca), 3'b100, 3'b001, 1'b1, 16'h0001};
        tbl[7]  = '{rd(3'b111, cr, ca), 3'b001, 3'b010, 1'b0, 16'h0};
        tbl[8]  = '{rd(3'b111, cr, ca), 3'b010, 3'b100, 1'b0, 16'h0};
        tbl[9]  = '{rd(3'b111, cr, ca), 3'b100, 3'b001, 1'b1, 16'h0001};
        tbl[10] = '{idle, 3'b000, 3'b010, 1'b0, 16'h0};
        tbl[11] = '{mk(1'b1, 1'b1, 4'b0010, 8'h10, 16'h1234, 3'b000, 6'h0, 24'h0), 3'b000, 3'b100, 1'b0, 16'h0};
        tbl[12] = '{mk(1'b1, 1'b1, 4'b1010, 8'h10, 16'hBEEF, 3'b001, 6'd1, 24'h10), 3'b001, 3'b000, 1'b0, 16'h0};
        tbl[13] = '{idle, 3'b000, 3'b000, 1'b0, 16'h0};
        tbl[14] = '{rd(3'b001, 6'd0, 24'h10), 3'b001, 3'b001, 1'b1, 16'h1234};
        tbl[15] = '{rd(3'b001, 6'd1, 24'h10), 3'b001, 3'b000, 1'b0, 16'h0};
        tbl[16] = '{rd(3'b001, 6'd2, 24'h10), 3'b001, 3'b001, 1'b1, 16'h0010};
        tbl[17] = '{rd(3'b001, 6'd3, 24'h10), 3'b001, 3'b001, 1'b1, 16'hBEEF};
        tbl[18] = '{idle, 3'b000, 3'b001, 1'b1, 16'h0210};
        tbl[19] = '{idle, 3'b000, 3'b001, 1'b1, 16'hBEEF};
        tbl[20] = '{idle, 3'b000, 3'b000, 1'b1, 16'hBEEF};
        for (int i = 0; i < 21; i++) begin
            cyc(tbl[i].in);
            chk($sformatf("tbl%0d_gnt", i), 64'(obs_gnt), 64'(tbl[i].exp_gnt));
            chk($sformatf("tbl%0d_vld", i), 64'(obs_vld), 64'(tbl[i].exp_vld));
            if (tbl[i].chk_d0) begin
                chk($sformatf("tbl%0d_rdata0", i), 64'(obs_rdata[15:0]), 64'(tbl[i].exp_d0));
            end
        end

        // Fairness: ch1 streams, ch2 asks once and must win straight away
        cyc(rd(3'b010, 6'h0, 24'h0));
        cyc(rd(3'b010, 6'h0, 24'h0));
        cyc(rd(3'b110, 6'h0, 24'h0));
        chk("fair_ch2_granted", 64'(obs_gnt), 64'b100);
        cyc(rd(3'b010, 6'h0, 24'h0));
        chk("fair_ch1_after", 64'(obs_gnt), 64'b010);

        // Pointer holds across idle cycles
        cyc(idle);
        cyc(idle);
        cyc(idle);
        cyc(rd(3'b101, 6'h0, 24'h0));
        chk("ptr_hold_ch2", 64'(obs_gnt), 64'b100);

        // Reset while a read is in flight
        cyc(rd(3'b001, 6'h0, 24'h10));
        chk("pre_rst_gnt", 64'(obs_gnt), 64'b001);
        cyc(mk(1'b0, 1'b1, 4'hF, 8'h10, 16'hDEAD, 3'b001, 6'h0, 24'h10));
        chk("rst_gnt", 64'(obs_gnt), 64'h0);
        chk("rst_vld", 64'(obs_vld), 64'h0);
        chk("rst_rdata", 64'(obs_rdata), 64'h0);
        cyc(idle);
        chk("rst_no_late_vld", 64'(obs_vld), 64'h0);
        cyc(rd(3'b111, 6'h0, 24'h10));
        chk("rst_first_ch0", 64'(obs_gnt), 64'b001);
        cyc(idle);
        cyc(idle);
        chk("rst_write_ignored", 64'(obs_rdata[15:0]), 64'h0010);

        // Out-of-range bank on the three-bank copy
        cyc(rd(3'b001, 6'd3, 24'h10));
        cyc(idle);
        cyc(idle);
        chk("nb3_vld", 64'(obs_vld3), 64'b001);
        chk("nb3_rdata_zero", 64'(obs_rdata3[15:0]), 64'h0);
        chk("nb4_bank3", 64'(obs_rdata[15:0]), 64'hBEEF);

        // Random traffic: requesters hold until granted, writes unrestricted
        for (int c = 0; c < NCH; c++) begin
            pend[c] = 1'b0;
            pb[c]   = 2'd0;
            pa[c]   = 8'd0;
            wt[c]   = 0;
        end
        for (int k = 0; k < 400; k++) begin
            in_t v;
            for (int c = 0; c < NCH; c++) begin
                if (!pend[c] && $urandom_range(0, 2) == 0) begin
                    pend[c] = 1'b1;
                    pb[c]   = 2'($urandom_range(0, 3));
                    pa[c]   = 8'($urandom);
                    wt[c]   = 0;
                end
            end
            v = mk(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom), 16'($urandom),
                   3'b000, 6'h0, 24'h0);
            for (int c = 0; c < NCH; c++) begin
                if (pend[c]) v.req = v.req | 3'(1 << c);
                v.rb = v.rb | (6'(pb[c]) << (2 * c));
                v.ra = v.ra | (24'(pa[c]) << (8 * c));
            end
            cyc(v);
            for (int c = 0; c < NCH; c++) begin
                if (pend[c]) begin
                    if (((m_gnt >> c) & 3'b001) != 3'b000) begin
                        chk($sformatf("wait_bound_ch%0d", c), 64'(wt[c] <= NCH - 1), 64'h1);
                        pend[c] = 1'b0;
                    end else begin
                        wt[c]++;
                    end
                end
            end
        end
        cyc(idle);
        cyc(idle);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wave_ram_arbiter.md
WAVE_RAM_ARBITER -- requirements
Module: wave_ram_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 3, giving the number of wavetable reader channels.
REQ-002 The module SHALL have parameter NUM_BANKS, default 4, giving the number of wave banks.
REQ-003 The module SHALL have parameter DATAWIDTH, default 16, giving the sample width.
REQ-004 The module SHALL have parameter ADDRWIDTH, default 8, giving the per-bank address width (depth 2^ADDRWIDTH).
REQ-005 The module SHALL derive BANKW = clog2(NUM_BANKS), minimum 1.
REQ-006 Port clk, input, 1: sole clock; all logic on its rising edge.
REQ-007 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 Port WE, input, 1: write strobe, one word per cycle.
REQ-009 Port WBANK, input, NUM_BANKS: one-hot or multi-hot bank write mask.
REQ-010 Port WADDR, input, ADDRWIDTH: write address.
REQ-011 Port WDATA, input, DATAWIDTH: write data.
REQ-012 Port RD_REQ, input, NUM_CH: per-channel read request.
REQ-013 Port RBANK, input, NUM_CH*BANKW: per-channel bank select, packed, channel 0 in the LSBs.
REQ-014 Port RADDR, input, NUM_CH*ADDRWIDTH: per-channel read address, packed.
REQ-015 Port RD_GNT, output, NUM_CH: one-hot grant pulse.
REQ-016 Port RD_VALID, output, NUM_CH: per-channel data-valid pulse.
REQ-017 Port RDATA, output, NUM_CH*DATAWIDTH: per-channel registered read data, held between updates.

Function
REQ-018 Write port SHALL be independent of reads and never stall them.
REQ-019 When WE=1, every bank whose WBANK bit is set SHALL store WDATA at WADDR on the clock edge; WBANK=0 SHALL write nothing.
REQ-020 Exactly one read SHALL be served per cycle, through a single shared read path.
REQ-021 Arbitration SHALL be round-robin: search starts at the channel after the last granted one, wrapping from NUM_CH-1 to 0.
REQ-022 RD_GNT SHALL be combinational from RD_REQ and the pointer; at most one bit SHALL be set.
REQ-023 A requester SHALL hold RD_REQ, RBANK and RADDR stable until the cycle its RD_GNT is high; the address is sampled in that cycle.
REQ-024 For a grant in cycle N, the memory read SHALL occur at edge N+1; RDATA for that channel SHALL update and RD_VALID SHALL pulse for one cycle in cycle N+2. Fixed latency is 2.
REQ-025 Back-to-back grants SHALL pipeline at full rate: one RD_VALID per cycle.
REQ-026 A channel holding RD_REQ continuously SHALL be re-granted no sooner than after every other requesting channel has been served once.
REQ-027 Worst-case grant wait SHALL be NUM_CH-1 cycles.
REQ-028 The pointer SHALL advance only on a grant; with no requests, the pointer SHALL hold and RD_GNT SHALL be 0.
REQ-029 A read and a write to the same bank and address in the same cycle SHALL return the old data.
REQ-030 An RBANK value >= NUM_BANKS SHALL be granted normally; RD_VALID SHALL pulse with RDATA = 0.
REQ-031 RDATA of channels without RD_VALID SHALL hold their previous value.

Reset
REQ-032 While rst_n=0, RD_GNT, RD_VALID, RDATA and the pipeline valid bits SHALL be 0, and the pointer SHALL be 0 (channel 0 has first priority).
REQ-033 Assertion of rst_n SHALL discard in-flight reads; no RD_VALID SHALL appear for grants issued before reset.
REQ-034 Memory contents SHALL NOT be reset.
REQ-035 Writes SHALL be ignored while rst_n=0.

Structure
REQ-036 DATAWIDTH, ADDRWIDTH, NUM_BANKS and NUM_CH defaults SHALL live in the shared synth package.
REQ-037 The BANKW derivation and packed-slice helpers SHALL also live in the shared synth package.
REQ-038 The round-robin arbiter SHALL be a sub-module, rr_arbiter, parametrised by NUM_CH.
REQ-039 Bank storage SHALL be inferred simple dual-port RAM, one array per bank, mappable to SB_RAM40_4K.

Verification
REQ-040 Fill: write bank b, address a with {b,a} for all b and a, then single-channel sequential reads -> every RDATA equals {b,a} exactly 2 cycles after its grant.
REQ-041 Contention: NUM_CH=3, all RD_REQ held high for 9 cycles -> grants ch0,1,2,0,1,2,0,1,2 and 9 consecutive RD_VALID pulses.
REQ-042 Broadcast and collision: WBANK=4'b1010, WADDR=0x10, WDATA=0xBEEF, with a same-cycle read of bank 1 addr 0x10 (old 0x1234) -> reads 0x1234; a later read returns 0xBEEF in banks 1 and 3 and is unchanged in banks 0 and 2.
REQ-043 Fairness: ch1 requests continuously, ch2 requests once -> ch2 granted within 1 cycle of the next arbitration.
REQ-044 Reset mid-read: grant ch0, assert rst_n low at N+1 -> no RD_VALID, RDATA=0; after release the first grant goes to ch0.
REQ-045 Invalid bank: NUM_BANKS=3, RBANK=3 -> RD_VALID pulses with RDATA=0.
